// File: rtl/fifo_packer_pkg.sv
// Shared types and constants for the FIFO word packer.
package fifo_packer_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_LANES  = 4;
    localparam int COUNT_W        = 16;

    // FILL gathers FIFO words into lanes; OUT presents the packed word.
    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_packer.sv
// Pops words from an upstream FIFO and packs LANES of them into one wide
// output word with a valid/ready handshake. A flush emits a partial word.
module fifo_packer
    import fifo_packer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LANES  = DEFAULT_LANES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fifo_empty,
    output logic                      fifo_rd_en,
    input  logic [DATA_W-1:0]         fifo_rd_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W*LANES-1:0]   out_data,
    output logic [LANES-1:0]          out_keep,
    output logic [COUNT_W-1:0]        out_count
);

    // filled must reach LANES itself; lane indices only go to LANES-1.
    localparam int              FW        = $clog2(LANES + 1);
    localparam int              LW        = $clog2(LANES);
    localparam logic [FW:0]     LANES_OCC = (FW + 1)'(LANES);
    localparam logic [FW-1:0]   LAST_LANE = FW'(LANES - 1);

    state_t             state;
    state_t             state_next;
    logic [FW-1:0]      filled;
    logic               inflight;
    logic               flush_pending;
    logic [DATA_W-1:0]  lanes [LANES];
    logic [FW:0]        occupancy;
    logic               handshake;

    // Words already captured plus the one arriving this cycle.
    assign occupancy = {1'b0, filled} + {{FW{1'b0}}, inflight};
    assign out_valid = (state == OUT);
    assign handshake = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every flop samples the
        // pre-edge values of the others, independent of statement order.
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the combinational pop request.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case leaves a signal unassigned and infers a latch.
        state_next = state;
        fifo_rd_en = 1'b0;
        case (state)
            FILL: begin
                fifo_rd_en = !rst && !fifo_empty && !flush_pending
                             && (occupancy < LANES_OCC);
                if (inflight) begin
                    // The last lane lands on this edge: present next cycle.
                    if (filled == LAST_LANE) begin
                        state_next = OUT;
                    end
                end else if (flush_pending && (filled != '0)) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Lane capture, fill level, flush request and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            filled        <= '0;
            inflight      <= 1'b0;
            flush_pending <= 1'b0;
            out_count     <= '0;
            // NOTE: the lane array is reset because it drives out_data
            // directly and unfilled lanes must read as zero.
            for (int i = 0; i < LANES; i++) begin
                lanes[i] <= '0;
            end
        end else begin
            inflight <= fifo_rd_en;
            if (handshake) begin
                out_count     <= out_count + 1'b1;
                filled        <= '0;
                flush_pending <= 1'b0;
                for (int i = 0; i < LANES; i++) begin
                    lanes[i] <= '0;
                end
            end else if (state == FILL) begin
                if (inflight) begin
                    lanes[filled[LW-1:0]] <= fifo_rd_data;
                    filled                <= filled + FW'(1);
                end
                // An empty flush has nothing to emit and simply retires.
                if (flush_pending && !inflight && (filled == '0)) begin
                    flush_pending <= 1'b0;
                end else if (flush) begin
                    flush_pending <= 1'b1;
                end
            end
        end
    end

    // Pack lanes with lane 0 in the least significant bits.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < LANES; i++) begin
            out_data[i*DATA_W +: DATA_W] = lanes[i];
        end
    end

    // Keep mask marks the lanes that hold captured words.
    always_comb begin
        out_keep = '0;
        if (state == OUT) begin
            for (int i = 0; i < LANES; i++) begin
                out_keep[i] = (FW'(i) < filled);
            end
        end
    end

endmodule
